// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} kp_state_e;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} kp_frame_e;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  function automatic logic [1:0] low_idx4(input logic [3:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int i = 3; i >= 0; i--) if (v[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/keypad_row_scan.sv
// Row prescaler: one scan tick on the last cycle of each row slot, one-cold row drive.
module keypad_row_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic               clk_50MHz_i,
  input  logic               rst_async_la_i,
  output logic               tick_o,
  output logic [1:0]         row_idx_o,
  output logic [KP_ROWS-1:0] row_o
);
  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0]      pre_q, pre_d;
  logic [1:0]         row_idx_q, row_idx_d;
  logic [KP_ROWS-1:0] row_q, row_d;
  logic               tick;

  assign tick = (pre_q == PW'(SCAN_DIV - 1));

  always_comb begin
    pre_d     = tick ? '0 : pre_q + 1'b1;
    row_idx_d = tick ? row_idx_q + 2'd1 : row_idx_q;
    row_d     = ~(4'b0001 << row_idx_d);
  end

  // Row pins come straight from a flop so the matrix never sees decode glitches.
  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      pre_q     <= '0;
      row_idx_q <= '0;
      row_q     <= 4'b1110;
    end else begin
      pre_q     <= pre_d;
      row_idx_q <= row_idx_d;
      row_q     <= row_d;
    end
  end

  assign tick_o    = tick;
  assign row_idx_o = row_idx_q;
  assign row_o     = row_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: synchronize, classify each frame, debounce press/release,
// and hand one code per press to the consumer through a valid/ack holding register.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic               clk_50MHz_i,
  input  logic               rst_async_la_i,
  input  logic [KP_COLS-1:0] col_i,
  output logic [KP_ROWS-1:0] row_o,
  input  logic               key_ack_i,
  output logic [3:0]         key_code_o,
  output logic               key_valid_o,
  output logic               pressed_o,
  output logic               overrun_o
);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  logic       tick;
  logic [1:0] row_idx;

  keypad_row_scan #(.SCAN_DIV(SCAN_DIV)) u_row_scan (
    .clk_50MHz_i    (clk_50MHz_i),
    .rst_async_la_i (rst_async_la_i),
    .tick_o         (tick),
    .row_idx_o      (row_idx),
    .row_o          (row_o)
  );

  logic [KP_COLS-1:0] sync1_q, sync2_q;
  logic [1:0]         acc_n_q, acc_n_d;
  logic [3:0]         acc_code_q, acc_code_d;
  kp_state_e          state_q, state_d;
  logic [3:0]         cand_q, cand_d;
  logic [CW-1:0]      cnt_q, cnt_d, rel_q, rel_d;
  logic [3:0]         code_q, code_d;
  logic               valid_q, valid_d, ovr_q, ovr_d, pressed_q;

  logic [3:0] row_hits;
  logic [1:0] base_n;
  logic [2:0] sum_n;
  logic       frame_end, emit;
  kp_frame_e  fr;
  logic [CW-1:0] cnt_inc, rel_inc;

  // Key count saturates at 2: only none / one / many matters for a frame.
  always_comb begin
    row_hits   = ~sync2_q;
    base_n     = (row_idx == 2'd0) ? 2'd0 : acc_n_q;
    sum_n      = {1'b0, base_n} + popcnt4(row_hits);
    acc_n_d    = acc_n_q;
    acc_code_d = acc_code_q;
    if (tick) begin
      acc_n_d    = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
      acc_code_d = (base_n == 2'd0) ? {row_idx, low_idx4(row_hits)} : acc_code_q;
    end
    frame_end = tick && (row_idx == 2'd3);
    fr        = (acc_n_d == 2'd0) ? NONE : (acc_n_d == 2'd1) ? SINGLE : MULTI;
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    emit    = 1'b0;
    cnt_inc = (cnt_q == CW'(DEBOUNCE_CNT)) ? cnt_q : cnt_q + 1'b1;
    rel_inc = (rel_q == CW'(DEBOUNCE_CNT)) ? rel_q : rel_q + 1'b1;
    if (frame_end) begin
      case (state_q)
        IDLE: if (fr == SINGLE) begin
          cand_d = acc_code_d;
          cnt_d  = CW'(1);
          if (DEBOUNCE_CNT == 1) begin
            emit    = 1'b1;
            state_d = PRESSED;
            rel_d   = '0;
          end else begin
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (fr == SINGLE && acc_code_d == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_CNT)) begin
              emit    = 1'b1;
              state_d = PRESSED;
              rel_d   = '0;
            end
          end else if (fr == SINGLE) begin
            cand_d = acc_code_d;
            cnt_d  = CW'(1);
          end else begin
            state_d = IDLE;
          end
        end
        PRESSED: begin
          if (fr == NONE) begin
            rel_d = rel_inc;
            if (rel_inc == CW'(DEBOUNCE_CNT)) state_d = IDLE;
          end else begin
            rel_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A same-cycle ack frees the slot, so the new code replaces the old one cleanly.
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (emit) begin
      if (!valid_q) begin
        code_d  = acc_code_d;
        valid_d = 1'b1;
      end else if (key_ack_i) begin
        code_d = acc_code_d;
        ovr_d  = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (key_ack_i && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      acc_n_q    <= '0;
      acc_code_q <= '0;
      state_q    <= IDLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      rel_q      <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      pressed_q  <= 1'b0;
    end else begin
      sync1_q    <= col_i;
      sync2_q    <= sync1_q;
      acc_n_q    <= acc_n_d;
      acc_code_q <= acc_code_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      rel_q      <= rel_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      pressed_q  <= (state_d == PRESSED);
    end
  end

  assign key_code_o  = code_q;
  assign key_valid_o = valid_q;
  assign overrun_o   = ovr_q;
  assign pressed_o   = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Frame-aligned stimulus on a modelled key matrix; directed table plus random frames vs a frame-level model.
module tb_keypad_scanner;
  localparam int DB = 2;
  localparam int FRAME = 16;

  logic clk = 1'b0, rst_n = 1'b0, ack = 1'b0;
  logic [3:0] col, row, code;
  logic valid, pressed, ovr;
  logic [15:0] mask = '0;
  int n_chk = 0, n_pass = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(DB)) dut (
    .clk_50MHz_i(clk), .rst_async_la_i(rst_n), .col_i(col), .row_o(row),
    .key_ack_i(ack), .key_code_o(code), .key_valid_o(valid),
    .pressed_o(pressed), .overrun_o(ovr)
  );

  always #10 clk = ~clk;

  // Passive matrix: a held key (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  // Frame-level reference: one call per full scan with the key set held that frame.
  int m_st, m_cand, m_cnt, m_rel, m_code;
  bit m_valid, m_ovr;

  task automatic model_reset();
    m_st = 0; m_cand = 0; m_cnt = 0; m_rel = 0; m_code = 0; m_valid = 0; m_ovr = 0;
  endtask

  task automatic model_ack();
    if (m_valid) begin m_valid = 0; m_ovr = 0; end
  endtask

  task automatic model_frame(input logic [15:0] mk, input bit ack_end);
    int n, c;
    bit emit;
    n = $countones(mk); c = 0; emit = 0;
    for (int i = 0; i < 16; i++) if (mk[i]) c = i;
    if (m_st == 0) begin
      if (n == 1) begin
        m_cand = c; m_cnt = 1;
        if (m_cnt >= DB) begin emit = 1; m_st = 2; m_rel = 0; end else m_st = 1;
      end
    end else if (m_st == 1) begin
      if (n == 1 && c == m_cand) begin
        m_cnt++;
        if (m_cnt >= DB) begin emit = 1; m_st = 2; m_rel = 0; end
      end else if (n == 1) begin m_cand = c; m_cnt = 1; end
      else m_st = 0;
    end else begin
      if (n == 0) begin m_rel++; if (m_rel >= DB) m_st = 0; end
      else m_rel = 0;
    end
    if (emit) begin
      if (!m_valid) begin m_code = c; m_valid = 1; end
      else if (ack_end) begin m_code = c; m_ovr = 0; end
      else m_ovr = 1;
    end else if (ack_end) model_ack();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Starts right after a frame-boundary edge; ack_cyc 15 lands on the frame-end cycle, 16 = none.
  task automatic run_frame(input logic [15:0] mk, input int ack_cyc);
    mask = mk;
    for (int i = 0; i < FRAME; i++) begin
      ack = (i == ack_cyc);
      if (i == ack_cyc && i != FRAME - 1) model_ack();
      @(posedge clk); #1;
    end
    ack = 1'b0;
    model_frame(mk, ack_cyc == FRAME - 1);
  endtask

  function automatic logic [31:0] outs();
    return {25'd0, pressed, ovr, valid, code};
  endfunction

  function automatic logic [31:0] pack(input bit p, input bit o, input bit v, input logic [3:0] c);
    return {25'd0, p, o, v, c};
  endfunction

  typedef struct {
    logic [15:0] mk;
    int          ack_cyc;
    bit          p, o, v;
    logic [3:0]  c;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [15:0] mk, input int a, input bit p, input bit o, input bit v, input logic [3:0] c);
    vec_t e;
    e.mk = mk; e.ack_cyc = a; e.p = p; e.o = o; e.v = v; e.c = c;
    tbl.push_back(e);
  endtask

  initial begin
    logic [3:0] exp_row;
    logic [15:0] mk;
    int hold, ac;

    // (2,1) held ten frames, release, ack
    add(16'h0200, 16, 0, 0, 0, 4'h0);
    for (int i = 0; i < 9; i++) add(16'h0200, 16, 1, 0, 1, 4'h9);
    add(16'h0000, 16, 1, 0, 1, 4'h9);
    add(16'h0000, 16, 0, 0, 1, 4'h9);
    add(16'h0000, 16, 0, 0, 1, 4'h9);
    add(16'h0000, 5,  0, 0, 0, 4'h9);
    // (0,3) bouncing frame by frame
    for (int i = 0; i < 4; i++) begin
      add(16'h0008, 16, 0, 0, 0, 4'h9);
      add(16'h0000, 16, 0, 0, 0, 4'h9);
    end
    // (1,1) unacked, then (1,3) overruns, then ack clears both
    add(16'h0020, 16, 0, 0, 0, 4'h9);
    add(16'h0020, 16, 1, 0, 1, 4'h5);
    add(16'h0000, 16, 1, 0, 1, 4'h5);
    add(16'h0000, 16, 0, 0, 1, 4'h5);
    add(16'h0080, 16, 0, 0, 1, 4'h5);
    add(16'h0080, 16, 1, 1, 1, 4'h5);
    add(16'h0080, 16, 1, 1, 1, 4'h5);
    add(16'h0000, 16, 1, 1, 1, 4'h5);
    add(16'h0000, 5,  0, 0, 0, 4'h5);
    // (0,0)+(1,2) together, then (0,0) lifted
    add(16'h0041, 16, 0, 0, 0, 4'h5);
    add(16'h0041, 16, 0, 0, 0, 4'h5);
    add(16'h0040, 16, 0, 0, 0, 4'h5);
    add(16'h0040, 16, 1, 0, 1, 4'h6);
    add(16'h0000, 16, 1, 0, 1, 4'h6);
    add(16'h0000, 16, 0, 0, 1, 4'h6);
    add(16'h0000, 5,  0, 0, 0, 4'h6);
    // emit coinciding with ack replaces the held code
    add(16'h0400, 16, 0, 0, 0, 4'h6);
    add(16'h0400, 16, 1, 0, 1, 4'hA);
    add(16'h0000, 16, 1, 0, 1, 4'hA);
    add(16'h0000, 16, 0, 0, 1, 4'hA);
    add(16'h0800, 16, 0, 0, 1, 4'hA);
    add(16'h0800, 15, 1, 0, 1, 4'hB);
    add(16'h0000, 16, 1, 0, 1, 4'hB);
    add(16'h0000, 16, 0, 0, 1, 4'hB);
    add(16'h0000, 5,  0, 0, 0, 4'hB);
    // candidate change restarts the count; MULTI while pressed restarts release
    add(16'h0002, 16, 0, 0, 0, 4'hB);
    add(16'h0004, 16, 0, 0, 0, 4'hB);
    add(16'h0004, 16, 1, 0, 1, 4'h2);
    add(16'h0000, 16, 1, 0, 1, 4'h2);
    add(16'h0006, 16, 1, 0, 1, 4'h2);
    add(16'h0000, 16, 1, 0, 1, 4'h2);
    add(16'h0000, 16, 0, 0, 1, 4'h2);
    add(16'h0000, 5,  0, 0, 0, 4'h2);
    // (1,0) held so a key is valid and pressed before the mid-run reset
    add(16'h0010, 16, 0, 0, 0, 4'h2);
    add(16'h0010, 16, 1, 0, 1, 4'h4);
    add(16'h8000, 16, 1, 0, 1, 4'h4);

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_row", {28'd0, row}, 32'h0000_000E);
    check("reset_outs", outs(), pack(0, 0, 0, 4'h0));
    rst_n = 1'b1;

    for (int k = 1; k <= 2 * FRAME; k++) begin
      @(posedge clk); #1;
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      check($sformatf("row_step_%0d", k), {28'd0, row}, {28'd0, exp_row});
    end
    model_frame(16'h0000, 0);
    model_frame(16'h0000, 0);

    foreach (tbl[i]) begin
      run_frame(tbl[i].mk, tbl[i].ack_cyc);
      check($sformatf("vec_%0d", i), outs(), pack(tbl[i].p, tbl[i].o, tbl[i].v, tbl[i].c));
    end

    // reset mid-run with (3,3) still held
    rst_n = 1'b0;
    #1;
    check("midreset_row", {28'd0, row}, 32'h0000_000E);
    check("midreset_outs", outs(), pack(0, 0, 0, 4'h0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check("release_outs", outs(), pack(0, 0, 0, 4'h0));
    run_frame(16'h8000, 16);
    check("post_reset_f1", outs(), pack(0, 0, 0, 4'h0));
    run_frame(16'h8000, 16);
    check("post_reset_f2", outs(), pack(1, 0, 1, 4'hF));

    for (int it = 0; it < 80; it++) begin
      ac = $urandom_range(0, 9);
      if (ac < 4) mk = '0;
      else if (ac < 8) mk = 16'd1 << $urandom_range(0, 15);
      else begin
        mk = 16'd1 << $urandom_range(0, 15);
        mk = mk | (16'd1 << $urandom_range(0, 15));
        if ($countones(mk) < 2) mk = mk | (mk == 16'h8000 ? 16'h0001 : mk << 1);
      end
      hold = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) begin
        ac = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 5 : 15) : 16;
        run_frame(mk, ac);
        check($sformatf("rand_%0d_%0d mask=%h", it, h, mk), outs(),
              pack(m_st == 2, m_ovr, m_valid, 4'(m_code)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display: scans a 4x4 passive key matrix by driving rows one-cold and reading columns.
- Synchronizes and debounces the column inputs, then delivers one key code per debounced press through a valid/ack holding register.
- Sits between board pins and the game/control logic, in the same 50 MHz domain as the display driver.

Parameters:
- SCAN_DIV, 50000, clock cycles per row slot (1 kHz row rate at 50 MHz); legal range >= 4.
- DEBOUNCE_CNT, 4, consecutive identical full-scan frames required to accept a press and to accept a release; legal range >= 1.

Ports:
- clk_50MHz_i  in  1  system clock.
- rst_async_la_i  in  1  reset, asynchronous, active-low.
- col_i  in  4  matrix columns, active-low (pulled up), asynchronous to the clock.
- row_o  out  4  matrix rows, one-cold active-low drive.
- key_ack_i  in  1  consumer acknowledge; consumes the held key.
- key_code_o  out  4  held key code = row*4 + col.
- key_valid_o  out  1  held key available; stays high until acknowledged.
- pressed_o  out  1  high while a debounced key is down.
- overrun_o  out  1  sticky: a press was lost because the previous key was not yet acknowledged.

Behaviour:
- Reset (async assert, sync release): row_idx=0 so row_o=4'b1110; key_code_o=0, key_valid_o=0, pressed_o=0, overrun_o=0; FSM=IDLE; all counters and the synchronizer cleared to "no press".
- Columns pass through a 2-FF synchronizer. The synchronized value is sampled on the last cycle of each row slot (scan tick), then row_idx increments mod 4.
- row_o = ~(1<<row_idx). A frame is the 4 slots for row 0..3, i.e. 4*SCAN_DIV cycles.
- Frame result is evaluated at the row-3 sample:
  - NONE: 0 keys down.
  - SINGLE(code): exactly 1 key down.
  - MULTI: 2 or more keys down.
- FSM evaluates only at frame end:
  - IDLE: SINGLE(c) -> DEBOUNCE with cand=c, cnt=1; otherwise stay.
  - DEBOUNCE:
    - SINGLE(cand): cnt++. When cnt reaches DEBOUNCE_CNT (with DEBOUNCE_CNT=1, directly from IDLE), emit cand and go to PRESSED with rel=0.
    - SINGLE(other): cand=other, cnt=1.
    - NONE or MULTI: -> IDLE.
  - PRESSED:
    - NONE: rel++; when rel reaches DEBOUNCE_CNT -> IDLE.
    - SINGLE or MULTI: rel=0. No further emits until release, so ghosting and second keys are ignored.
- pressed_o=1 exactly while FSM=PRESSED.
- Emit, registered, visible the cycle after frame end:
  - key_valid_o=0: load key_code_o, set key_valid_o=1.
  - key_valid_o=1 and no ack this cycle: new code dropped, key_code_o unchanged, overrun_o set.
  - Emit with ack in the same cycle: new code loaded, key_valid_o stays 1, no overrun.
- key_ack_i with key_valid_o=1 and no emit: key_valid_o=0, overrun_o=0. key_ack_i with key_valid_o=0 is ignored.
- Latency from a stable press to key_valid_o: between DEBOUNCE_CNT and DEBOUNCE_CNT+1 frames, plus 3 cycles.
- Widths:
  - Prescaler: clog2(SCAN_DIV) bits, wraps at SCAN_DIV-1.
  - cnt and rel: clog2(DEBOUNCE_CNT+1) bits, saturating.
- Reset mid-operation discards every partial frame, count and held key.

Decomposition:
- Package keypad_pkg:
  - FSM state typedef (IDLE, DEBOUNCE, PRESSED).
  - Frame-result typedef (NONE, SINGLE, MULTI).
  - Constants KP_ROWS=4 and KP_COLS=4.
- Sub-module keypad_row_scan: prescaler, scan tick, row_idx counter, one-cold row_o drive; outputs tick and row_idx.
- Top level holds the synchronizer, frame accumulator, FSM and output register.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=2, frame=16 cycles; the bench matrix model pulls col_i[c] low while row_o[r]=0 for every pressed key (r,c)):
- Reset held low -> row_o=4'b1110 and all outputs 0. After release, row_o steps 1110,1101,1011,0111, each held 4 cycles, repeating.
- Press (2,1) for 10 frames -> one key_valid_o rise, key_code_o=4'h9, within 3 frames + 3 cycles. pressed_o=1 until 2 NONE frames after release, and no second valid.
- Press (0,3) alternating 1 frame pressed / 1 frame released for 8 frames -> key_valid_o never rises, pressed_o stays 0.
- Press (1,1) -> code 5. Release without ack, then press (1,3) stable -> key_code_o stays 5 and overrun_o=1. Pulse key_ack_i -> key_valid_o=0, overrun_o=0.
- Hold (0,0) and (1,2) together -> no emit (MULTI). Release (0,0) -> emits 4'h6 after 2 SINGLE frames.
- Assert reset after the first matching frame of (3,3), then release it with the key still held -> all outputs 0 immediately. Emit 4'hF only after 2 further full matching frames.
